// File: rtl/gate_arb_pkg.sv
// Shared types and sizes for the four-way round-robin AND-gate sequencer.
package gate_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int OPW     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [NUM_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping mod 4.
// Latency: zero cycles; no backpressure, o_vld simply reports whether any request is set.
module rr_pick4
    import gate_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_vld,
    output logic [ID_W-1:0]    o_win
);

    logic [ID_W-1:0] w_idx;
    logic            w_found;

    always_comb begin
        o_vld   = |i_req;
        o_win   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = i_ptr + ID_W'(k);
            if (!w_found && i_req[w_idx]) begin
                o_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tt_um_gate_arbiter.sv
// Shares one registered 4-bit AND among four level requesters, granting round-robin.
// Latency: grant 1 cycle after req, result/done EXEC_CYCLES later; requesters wait by holding req high.
module tt_um_gate_arbiter
    import gate_arb_pkg::*;
#(
    parameter int EXEC_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

    logic [NUM_REQ-1:0] w_req;
    logic [OPW-1:0]     w_op_a;
    logic [OPW-1:0]     w_op_b;
    logic               w_pick_vld;
    logic [ID_W-1:0]    w_pick_id;
    logic               w_unused;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [ID_W-1:0]    r_win;
    logic [ID_W-1:0]    r_ptr;
    logic [3:0]         r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [ID_W-1:0]    r_last_id;
    logic [OPW-1:0]     r_result;

    assign w_req    = ui_in[3:0];
    assign w_op_a   = ui_in[7:4];
    assign w_op_b   = uio_in[3:0];
    assign w_unused = &{1'b0, uio_in[7:4]};

    rr_pick4 u_pick (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_vld (w_pick_vld),
        .o_win (w_pick_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_win     <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_last_id <= '0;
            r_result  <= '0;
        end else if (ena) begin
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_grant <= id2onehot(w_pick_id);
                        r_win   <= w_pick_id;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    // A dropped request wins over completion, even on the last cycle.
                    if (!w_req[r_win]) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_win + ID_W'(1);
                        r_state <= IDLE;
                    end else if (r_cnt == LAST_CNT) begin
                        r_result  <= w_op_a & w_op_b;
                        r_last_id <= r_win;
                        r_done    <= 1'b1;
                        r_grant   <= '0;
                        r_ptr     <= r_win + ID_W'(1);
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    r_done <= 1'b0;
                    if (w_pick_vld) begin
                        r_grant <= id2onehot(w_pick_id);
                        r_win   <= w_pick_id;
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign uo_out  = {r_done, r_busy, r_last_id, r_grant};
    assign uio_out = {r_result, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_gate_arbiter.sv
// Directed bench for the round-robin AND sequencer with hand-computed expectations.
module tb_tt_um_gate_arbiter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fail   = 0;

    tt_um_gate_arbiter #(.EXEC_CYCLES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ui_in  = 8'h00;
        uio_in = 8'h00;
        ena    = 1'b1;
        rst_n  = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
    endtask

    // Serve requester 2 (ptr becomes 3), then present req2 at the DONE arbitration.
    task automatic rr_after2(input logic [3:0] req2, input logic [3:0] exp_grant, input string tag);
        do_reset();
        ui_in  = 8'hF4;
        uio_in = 8'h02;
        step();
        check_eq({tag, "_g2"}, 32'(uo_out[3:0]), 32'h4);
        step();
        step();
        check_eq({tag, "_done2"}, 32'(uo_out[7]), 32'h1);
        ui_in = {4'hF, req2};
        step();
        check_eq(tag, 32'(uo_out[3:0]), 32'(exp_grant));
        check_eq({tag, "_done_fall"}, 32'(uo_out[7]), 32'h0);
        check_eq({tag, "_busy"}, 32'(uo_out[6]), 32'h1);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #1;
        check_eq("rst_uo", 32'(uo_out), 32'h00);
        check_eq("rst_uio_out", 32'(uio_out), 32'h00);
        check_eq("rst_uio_oe", 32'(uio_oe), 32'hF0);

        // Single request, A=F B=A
        do_reset();
        ui_in  = 8'hF1;
        uio_in = 8'h0A;
        step();
        check_eq("t1_grant", 32'(uo_out[3:0]), 32'h1);
        check_eq("t1_busy", 32'(uo_out[6]), 32'h1);
        check_eq("t1_done0", 32'(uo_out[7]), 32'h0);
        step();
        check_eq("t1_hold", 32'(uo_out[3:0]), 32'h1);
        check_eq("t1_done_early", 32'(uo_out[7]), 32'h0);
        step();
        check_eq("t1_done", 32'(uo_out[7]), 32'h1);
        check_eq("t1_result", 32'(uio_out[7:4]), 32'hA);
        check_eq("t1_last_id", 32'(uo_out[5:4]), 32'h0);
        check_eq("t1_grant_clr", 32'(uo_out[3:0]), 32'h0);
        check_eq("t1_busy_done", 32'(uo_out[6]), 32'h1);
        ui_in = 8'h00;
        step();
        check_eq("t1_busy_fall", 32'(uo_out[6]), 32'h0);
        check_eq("t1_done_fall", 32'(uo_out[7]), 32'h0);

        // All four requesting, back-to-back service in rotating order
        do_reset();
        ui_in  = 8'hFF;
        uio_in = 8'h00;
        step();
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("rr_grant%0d", k), 32'(uo_out[3:0]), 32'(1 << k));
            uio_in = 8'(k);
            step();
            check_eq($sformatf("rr_nodone%0d", k), 32'(uo_out[7]), 32'h0);
            step();
            check_eq($sformatf("rr_done%0d", k), 32'(uo_out[7]), 32'h1);
            check_eq($sformatf("rr_result%0d", k), 32'(uio_out[7:4]), 32'(k));
            check_eq($sformatf("rr_last_id%0d", k), 32'(uo_out[5:4]), 32'(k));
            step();
        end
        check_eq("rr_wrap", 32'(uo_out[3:0]), 32'h1);

        // Pointer after serving requester 2 is 3
        rr_after2(4'b0101, 4'b0001, "ptr3_0101");
        rr_after2(4'b0110, 4'b0010, "ptr3_0110");

        // Abort: requester 1 drops its request mid-window
        do_reset();
        ui_in  = 8'hF1;
        uio_in = 8'h05;
        step();
        step();
        step();
        check_eq("ab_pre_result", 32'(uio_out[7:4]), 32'h5);
        ui_in  = 8'hF0;
        step();
        ui_in  = 8'hF2;
        uio_in = 8'h0F;
        step();
        check_eq("ab_grant1", 32'(uo_out[3:0]), 32'h2);
        ui_in = 8'hF0;
        step();
        check_eq("ab_grant_clr", 32'(uo_out[3:0]), 32'h0);
        check_eq("ab_busy", 32'(uo_out[6]), 32'h0);
        check_eq("ab_done", 32'(uo_out[7]), 32'h0);
        check_eq("ab_result", 32'(uio_out[7:4]), 32'h5);
        check_eq("ab_last_id", 32'(uo_out[5:4]), 32'h0);
        step();
        check_eq("ab_no_late_done", 32'(uo_out[7]), 32'h0);
        ui_in = 8'hF7;
        step();
        check_eq("ab_ptr2", 32'(uo_out[3:0]), 32'h4);

        // ena freeze with one execution cycle remaining
        do_reset();
        ui_in  = 8'hF1;
        uio_in = 8'h03;
        step();
        step();
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq($sformatf("frz_grant%0d", k), 32'(uo_out), 32'h41);
        end
        ena = 1'b1;
        step();
        check_eq("frz_done", 32'(uo_out[7]), 32'h1);
        check_eq("frz_result", 32'(uio_out[7:4]), 32'h3);

        // Asynchronous reset mid-grant
        do_reset();
        ui_in  = 8'hF8;
        uio_in = 8'h09;
        step();
        step();
        step();
        check_eq("ar_pre_result", 32'(uio_out[7:4]), 32'h9);
        step();
        check_eq("ar_regrant", 32'(uo_out[3:0]), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_uo", 32'(uo_out), 32'h00);
        check_eq("ar_uio_out", 32'(uio_out), 32'h00);
        check_eq("ar_uio_oe", 32'(uio_oe), 32'hF0);
        ui_in = 8'hFA;
        step();
        rst_n = 1'b1;
        step();
        check_eq("ar_first_grant", 32'(uo_out[3:0]), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
